// File: rtl/byte_word_assembler.sv
// Packs a byte stream into NB-bit words, MSB byte first, and hands each word to a
// consumer through a valid/ready handshake. A separate output register allows
// the next word to be assembled while the previous one waits for the consumer.
module byte_word_assembler #(
    parameter int NB        = 32,
    parameter int NB_BYTE   = 8,
    parameter int NB_SELECT = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [NB_BYTE-1:0]   i_byte,
    input  logic                 i_flush,
    input  logic                 i_ready,
    output logic [NB-1:0]        o_word,
    output logic                 o_word_valid,
    output logic [NB_SELECT-1:0] o_lane,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int N_BYTES = NB / NB_BYTE;
    localparam logic [NB_SELECT-1:0] LAST_LANE = NB_SELECT'(N_BYTES - 1);

    logic [NB-1:0]        asm_q;
    logic [NB-1:0]        word_q;
    logic                 word_valid_q;
    logic [NB_SELECT-1:0] lane_q;
    logic                 overrun_q;

    logic                 out_free;
    logic                 at_last;
    logic                 complete;
    logic [NB-1:0]        asm_next;

    // Lane 0 is the most significant byte of the word.
    function automatic logic [NB-1:0] place_byte(
        input logic [NB-1:0]        word,
        input logic [NB_SELECT-1:0] lane,
        input logic [NB_BYTE-1:0]   data
    );
        int            shift;
        logic [NB-1:0] mask;
        shift = (N_BYTES - 1 - int'(lane)) * NB_BYTE;
        mask  = {{(NB-NB_BYTE){1'b0}}, {NB_BYTE{1'b1}}} << shift;
        return (word & ~mask) | ({{(NB-NB_BYTE){1'b0}}, data} << shift);
    endfunction

    always_comb begin
        out_free = !word_valid_q || i_ready;
        at_last  = (lane_q == LAST_LANE);
        complete = i_valid && !i_flush && at_last && out_free;
        asm_next = place_byte(asm_q, lane_q, i_byte);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            asm_q     <= '0;
            lane_q    <= '0;
            overrun_q <= 1'b0;
        end else if (i_flush) begin
            asm_q     <= '0;
            lane_q    <= '0;
            overrun_q <= 1'b0;
        end else if (i_valid) begin
            if (!at_last) begin
                asm_q  <= asm_next;
                lane_q <= lane_q + NB_SELECT'(1);
            end else if (out_free) begin
                asm_q  <= '0;
                lane_q <= '0;
            end else begin
                // Completing byte has nowhere to go; keep the partial lanes for a retry.
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else if (complete) begin
            word_q       <= asm_next;
            word_valid_q <= 1'b1;
        end else if (i_ready) begin
            word_valid_q <= 1'b0;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = word_valid_q;
    assign o_lane       = lane_q;
    assign o_busy       = (lane_q != '0);
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Bench for byte_word_assembler: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a byte-accumulating model.
module tb_byte_word_assembler;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [7:0]  data;
    logic        flush;
    logic        ready;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic [1:0]  o_lane;
    logic        o_busy;
    logic        o_overrun;

    int checks = 0;
    int errors = 0;

    // Model state: bytes collected so far, shifted in MSB-first
    logic [31:0] m_part;
    int          m_cnt;
    logic [31:0] m_word;
    logic        m_valid;
    logic        m_ovr;

    byte_word_assembler #(.NB(32), .NB_BYTE(8), .NB_SELECT(2)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_valid      (valid),
        .i_byte       (data),
        .i_flush      (flush),
        .i_ready      (ready),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .o_lane       (o_lane),
        .o_busy       (o_busy),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_part  <= '0;
            m_cnt   <= 0;
            m_word  <= '0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            if (flush) begin
                m_part <= '0;
                m_cnt  <= 0;
                m_ovr  <= 1'b0;
            end else if (valid) begin
                if (m_cnt < 3) begin
                    m_part <= (m_part << 8) | {24'd0, data};
                    m_cnt  <= m_cnt + 1;
                end else if (!m_valid || ready) begin
                    m_word <= (m_part << 8) | {24'd0, data};
                    m_part <= '0;
                    m_cnt  <= 0;
                end else begin
                    m_ovr <= 1'b1;
                end
            end
            if (!flush && valid && m_cnt == 3 && (!m_valid || ready))
                m_valid <= 1'b1;
            else if (ready)
                m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("word",    o_word,               m_word);
        check("valid",   {31'd0, o_word_valid}, {31'd0, m_valid});
        check("lane",    {30'd0, o_lane},       32'(m_cnt));
        check("busy",    {31'd0, o_busy},       {31'd0, m_cnt != 0});
        check("overrun", {31'd0, o_overrun},    {31'd0, m_ovr});
    end

    // Apply one cycle of inputs; returns at the next falling edge with outputs settled.
    task automatic cyc(input logic v, input logic [7:0] b, input logic r, input logic f);
        valid = v;
        data  = b;
        ready = r;
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        flush = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word",  o_word, 32'h0);
        check("rst_flags", {28'd0, o_word_valid, o_lane, o_busy} | {31'd0, o_overrun}, 32'h0);
        rst_n = 1'b1;

        // Basic pack
        cyc(1, 8'hDE, 1, 0); check("bp_lane1", {30'd0, o_lane}, 1);
        cyc(1, 8'hAD, 1, 0); check("bp_lane2", {30'd0, o_lane}, 2);
        cyc(1, 8'hBE, 1, 0); check("bp_lane3", {30'd0, o_lane}, 3);
        check("bp_busy", {31'd0, o_busy}, 1);
        cyc(1, 8'hEF, 1, 0);
        check("bp_word", o_word, 32'hDEADBEEF);
        check("bp_valid", {31'd0, o_word_valid}, 1);
        check("bp_lane0", {30'd0, o_lane}, 0);
        cyc(0, 8'h00, 1, 0); check("bp_drain", {31'd0, o_word_valid}, 0);

        // Back-pressure and overrun
        cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
        cyc(1, 8'h55, 0, 0); cyc(1, 8'h66, 0, 0); cyc(1, 8'h77, 0, 0);
        check("bk_hold", o_word, 32'h11223344);
        check("bk_lane", {30'd0, o_lane}, 3);
        cyc(1, 8'h88, 0, 0);
        check("bk_ovr", {31'd0, o_overrun}, 1);
        check("bk_hold2", o_word, 32'h11223344);
        cyc(1, 8'h99, 1, 0);
        check("bk_word", o_word, 32'h55667799);
        check("bk_valid", {31'd0, o_word_valid}, 1);

        // Flush clears overrun, then simultaneous drain and load
        cyc(0, 8'h00, 0, 1);
        check("fl_ovr", {31'd0, o_overrun}, 0);
        check("fl_keep", o_word, 32'h55667799);
        cyc(1, 8'hCA, 0, 0); cyc(1, 8'hFE, 0, 0); cyc(1, 8'hF0, 0, 0); cyc(1, 8'h0D, 1, 0);
        check("sim_word", o_word, 32'hCAFEF00D);
        check("sim_valid", {31'd0, o_word_valid}, 1);
        check("sim_ovr", {31'd0, o_overrun}, 0);
        cyc(0, 8'h00, 1, 0);

        // Flush beats a simultaneous byte
        cyc(1, 8'hAA, 1, 0); cyc(1, 8'hBB, 1, 0); cyc(1, 8'hCC, 1, 1);
        check("fl_lane", {30'd0, o_lane}, 0);
        cyc(1, 8'h01, 1, 0); cyc(1, 8'h02, 1, 0); cyc(1, 8'h03, 1, 0); cyc(1, 8'h04, 1, 0);
        check("fl_word", o_word, 32'h01020304);
        cyc(0, 8'h00, 1, 0);

        // Asynchronous reset mid-word
        cyc(1, 8'hA1, 0, 0); cyc(1, 8'hA2, 0, 0);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar_word", o_word, 32'h0);
        check("ar_lane", {30'd0, o_lane}, 0);
        check("ar_busy", {31'd0, o_busy}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 8'h0A, 1, 0); cyc(1, 8'h0B, 1, 0); cyc(1, 8'h0C, 1, 0); cyc(1, 8'h0D, 1, 0);
        check("ar_word2", o_word, 32'h0A0B0C0D);
        cyc(0, 8'h00, 1, 0);

        // Idle ready toggling
        for (int i = 0; i < 10; i++) cyc(0, 8'h00, i[0], 0);
        check("idle_valid", {31'd0, o_word_valid}, 0);
        check("idle_word", o_word, 32'h0A0B0C0D);

        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 3);

        valid = 1'b0;
        flush = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
